// File: rtl/beehive_vr_pkg.sv
// Shared VR commit-engine types: controller state encoding, replica state and log entry headers.
package beehive_vr_pkg;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    STATE_RD_REQ  = 3'd1,
    STATE_RD_RESP = 3'd2,
    CHECK         = 3'd3,
    LOG_RD_REQ    = 3'd4,
    LOG_RD_RESP   = 3'd5,
    LOG_WR        = 3'd6,
    STATE_WR      = 3'd7
  } commit_eng_state_e;

  typedef enum logic [1:0] {
    LOG_EMPTY    = 2'd0,
    LOG_PREPARED = 2'd1,
    LOG_COMMITED = 2'd2
  } log_entry_state_e;

  typedef struct packed {
    logic [31:0] view;
    logic [31:0] last_commit;
    logic [31:0] last_op;
    logic [31:0] log_head;
  } vr_state_t;

  typedef struct packed {
    log_entry_state_e state;
    logic [31:0]      view;
    logic [31:0]      op_num;
    logic [15:0]      line_cnt;
  } log_entry_hdr_t;

endpackage

// File: rtl/commit_eng_ctrl.sv
// Commit-engine control FSM: reads VR state, validates the commit, walks and marks the log,
// then writes back last_commit and the advanced log_head.
module commit_eng_ctrl
  import beehive_vr_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             manage_commit_req_val,
  output logic             manage_commit_req_rdy,
  output logic             commit_state_rd_req_val,
  input  logic             commit_state_rd_req_rdy,
  input  logic             vr_state_commit_rd_resp_val,
  output logic             commit_state_rd_resp_rdy,
  output logic             commit_vr_state_wr_val,
  input  logic             vr_state_commit_wr_rdy,
  output logic             commit_log_mem_rd_req_val,
  input  logic             log_mem_commit_rd_req_rdy,
  input  logic             log_mem_commit_rd_resp_val,
  output logic             commit_log_mem_rd_resp_rdy,
  output logic             commit_log_mem_wr_val,
  input  logic             log_mem_commit_wr_rdy,
  output logic             ctrl_datap_store_msg,
  output logic             ctrl_datap_store_state,
  output logic             ctrl_datap_store_log_entry,
  output logic             ctrl_datap_calc_next_entry,
  input  logic             datap_ctrl_commit_ok,
  input  logic             datap_ctrl_last_commit,
  output logic             commit_busy,
  output logic [CNT_W-1:0] commit_done_cnt,
  output logic [CNT_W-1:0] commit_drop_cnt
);

  commit_eng_state_e r_state;
  commit_eng_state_e w_state_next;
  logic [CNT_W-1:0]  r_done_cnt;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic w_msg_fire;
  logic w_st_rd_fire;
  logic w_st_resp_fire;
  logic w_st_wr_fire;
  logic w_log_rd_fire;
  logic w_log_resp_fire;
  logic w_log_wr_fire;
  logic w_drop;

  // Acceptance is held off while reset is asserted so no message is latched during reset.
  assign manage_commit_req_rdy      = (r_state == IDLE) && !rst;
  assign commit_state_rd_req_val    = (r_state == STATE_RD_REQ);
  assign commit_state_rd_resp_rdy   = (r_state == STATE_RD_RESP);
  assign commit_log_mem_rd_req_val  = (r_state == LOG_RD_REQ);
  assign commit_log_mem_rd_resp_rdy = (r_state == LOG_RD_RESP);
  assign commit_log_mem_wr_val      = (r_state == LOG_WR);
  assign commit_vr_state_wr_val     = (r_state == STATE_WR);
  assign commit_busy                = (r_state != IDLE);

  assign w_msg_fire      = manage_commit_req_val & manage_commit_req_rdy;
  assign w_st_rd_fire    = commit_state_rd_req_val & commit_state_rd_req_rdy;
  assign w_st_resp_fire  = commit_state_rd_resp_rdy & vr_state_commit_rd_resp_val;
  assign w_st_wr_fire    = commit_vr_state_wr_val & vr_state_commit_wr_rdy;
  assign w_log_rd_fire   = commit_log_mem_rd_req_val & log_mem_commit_rd_req_rdy;
  assign w_log_resp_fire = commit_log_mem_rd_resp_rdy & log_mem_commit_rd_resp_val;
  assign w_log_wr_fire   = commit_log_mem_wr_val & log_mem_commit_wr_rdy;
  assign w_drop          = (r_state == CHECK) && !datap_ctrl_commit_ok;

  assign ctrl_datap_store_msg       = w_msg_fire;
  assign ctrl_datap_store_state     = w_st_resp_fire;
  assign ctrl_datap_store_log_entry = w_log_resp_fire;
  assign ctrl_datap_calc_next_entry = w_log_wr_fire;

  assign commit_done_cnt = r_done_cnt;
  assign commit_drop_cnt = r_drop_cnt;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:          if (w_msg_fire) w_state_next = STATE_RD_REQ;
      STATE_RD_REQ:  if (w_st_rd_fire) w_state_next = STATE_RD_RESP;
      STATE_RD_RESP: if (w_st_resp_fire) w_state_next = CHECK;
      CHECK:         w_state_next = datap_ctrl_commit_ok ? LOG_RD_REQ : IDLE;
      LOG_RD_REQ:    if (w_log_rd_fire) w_state_next = LOG_RD_RESP;
      LOG_RD_RESP:   if (w_log_resp_fire) w_state_next = LOG_WR;
      // last_commit reflects the entry just written; the address advances on this same edge.
      LOG_WR:        if (w_log_wr_fire) w_state_next = datap_ctrl_last_commit ? STATE_WR : LOG_RD_REQ;
      STATE_WR:      if (w_st_wr_fire) w_state_next = IDLE;
      default:       w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_done_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_st_wr_fire) r_done_cnt <= r_done_cnt + CNT_W'(1);
      if (w_drop)       r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

endmodule
